// File: rtl/pcie_us_rq_tag_alloc.sv
// PCIe requester tag allocator: shares one tag space between several requester
// ports with round-robin, zero-latency grants and a release port from RC logic.
module pcie_us_rq_tag_alloc #(
  parameter int TAG_WIDTH = 5,
  parameter int TAG_COUNT = 2**TAG_WIDTH,
  parameter int PORTS     = 2
) (
  input  logic                 user_clk,
  input  logic                 user_reset,
  input  logic [PORTS-1:0]     req_valid,
  output logic [PORTS-1:0]     req_ready,
  output logic [TAG_WIDTH-1:0] req_tag,
  input  logic [TAG_WIDTH:0]   tag_limit,
  input  logic                 release_valid,
  input  logic [TAG_WIDTH-1:0] release_tag,
  output logic [TAG_WIDTH:0]   tags_in_use,
  output logic                 tags_full,
  output logic                 release_error
);

  localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [TAG_WIDTH:0] TAG_COUNT_W = (TAG_WIDTH+1)'(TAG_COUNT);

  logic [TAG_COUNT-1:0] in_use_q, in_use_d;
  logic [TAG_WIDTH:0]   count_q, count_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 release_error_q, release_error_d;

  logic [TAG_WIDTH-1:0] free_tag;
  logic                 free_found;
  logic [TAG_WIDTH:0]   eff_limit;
  logic                 alloc_ok;
  logic [PORTS-1:0]     grant_oh;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_found;
  logic                 grant;
  logic                 rel_hit;

  assign eff_limit = (tag_limit > TAG_COUNT_W) ? TAG_COUNT_W : tag_limit;

  // Scanning downwards leaves the lowest-index clear bit as the final winner.
  always_comb begin
    free_tag   = '0;
    free_found = 1'b0;
    for (int t = TAG_COUNT - 1; t >= 0; t--) begin
      if (!in_use_q[t]) begin
        free_tag   = TAG_WIDTH'(t);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      int p;
      p = (int'(rr_ptr_q) + i) % PORTS;
      if (!grant_found && req_valid[p]) begin
        grant_found = 1'b1;
        grant_oh[p] = 1'b1;
        grant_idx   = PTR_W'(p);
      end
    end
  end

  assign alloc_ok  = !user_reset && free_found && (count_q < eff_limit);
  assign req_ready = alloc_ok ? grant_oh : '0;
  assign req_tag   = free_tag;
  assign grant     = |(req_valid & req_ready);

  // A tag being granted is clear in the bitmap, so a release of it is an error
  // and the set/clear terms below never touch the same bit.
  assign rel_hit         = release_valid && in_use_q[release_tag];
  assign release_error_d = release_valid && !in_use_q[release_tag];

  genvar gi;
  for (gi = 0; gi < TAG_COUNT; gi++) begin : g_bit
    assign in_use_d[gi] = (in_use_q[gi] | (grant && (free_tag == TAG_WIDTH'(gi))))
                        & ~(rel_hit && (release_tag == TAG_WIDTH'(gi)));
  end

  assign count_d  = count_q + (TAG_WIDTH+1)'(grant) - (TAG_WIDTH+1)'(rel_hit);
  assign rr_ptr_d = grant ? PTR_W'((int'(grant_idx) + 1) % PORTS) : rr_ptr_q;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      in_use_q        <= '0;
      count_q         <= '0;
      rr_ptr_q        <= '0;
      release_error_q <= 1'b0;
    end else begin
      in_use_q        <= in_use_d;
      count_q         <= count_d;
      rr_ptr_q        <= rr_ptr_d;
      release_error_q <= release_error_d;
    end
  end

  assign tags_in_use   = count_q;
  assign tags_full     = (count_q >= eff_limit) || (count_q == TAG_COUNT_W);
  assign release_error = release_error_q;

endmodule

// File: tb/tb_pcie_us_rq_tag_alloc.sv
// Bench for pcie_us_rq_tag_alloc: directed scenarios then random traffic, all
// checked against a tag-set reference model evaluated once per cycle.
module tb_pcie_us_rq_tag_alloc;
  localparam int TW = 5;
  localparam int TC = 32;
  localparam int P  = 2;

  logic          user_clk = 1'b0;
  logic          user_reset;
  logic [P-1:0]  req_valid;
  logic [P-1:0]  req_ready;
  logic [TW-1:0] req_tag;
  logic [TW:0]   tag_limit;
  logic          release_valid;
  logic [TW-1:0] release_tag;
  logic [TW:0]   tags_in_use;
  logic          tags_full;
  logic          release_error;

  always #5 user_clk = ~user_clk;

  pcie_us_rq_tag_alloc #(.TAG_WIDTH(TW), .PORTS(P)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .tag_limit(tag_limit), .release_valid(release_valid), .release_tag(release_tag),
    .tags_in_use(tags_in_use), .tags_full(tags_full), .release_error(release_error)
  );

  // Reference model: set of held tags, count, next port to favour, error flag.
  bit m_busy [TC];
  int m_count;
  int m_rr;
  bit m_err;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < TC; i++) m_busy[i] = 1'b0;
    m_count = 0;
    m_rr    = 0;
    m_err   = 1'b0;
  endtask

  function automatic int held_count();
    int n = 0;
    for (int i = 0; i < TC; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic int pick_busy();
    int s = $urandom_range(0, TC - 1);
    for (int k = 0; k < TC; k++) if (m_busy[(s + k) % TC]) return (s + k) % TC;
    return s;
  endfunction

  // One clock cycle; entered and left at a falling edge.
  task automatic step(input bit rst, input logic [P-1:0] v, input int lim,
                      input bit rv, input int rt);
    int eff, free_t, gp;
    bit ok;
    logic [P-1:0] exp_rdy;
    check("tags_in_use", tags_in_use, m_count);
    check("release_error", release_error, m_err);
    check("invariant", $countones(dut.in_use_q), dut.count_q);

    user_reset    = rst;
    req_valid     = v;
    tag_limit     = lim[TW:0];
    release_valid = rv;
    release_tag   = rt[TW-1:0];
    #1;

    eff = (lim > TC) ? TC : lim;
    free_t = -1;
    for (int i = TC - 1; i >= 0; i--) if (!m_busy[i]) free_t = i;
    ok = !rst && (free_t >= 0) && (m_count < eff);
    gp = -1;
    for (int k = 0; k < P; k++) if (gp < 0 && v[(m_rr + k) % P]) gp = (m_rr + k) % P;
    exp_rdy = '0;
    if (ok && gp >= 0) exp_rdy[gp] = 1'b1;

    check("req_ready", req_ready, exp_rdy);
    if (exp_rdy != '0) check("req_tag", req_tag, free_t);
    check("tags_full", tags_full, (m_count >= eff) || (m_count == TC));
    $display("cyc %0d rst=%0b valid=%b ready=%b tag=%0d rel=%0b/%0d limit=%0d in_use=%0d err=%0b",
             cyc, rst, v, req_ready, req_tag, rv, rt, lim, tags_in_use, release_error);

    if (rst) begin
      model_reset();
    end else begin
      m_err = rv && !m_busy[rt];
      if (exp_rdy != '0) begin
        m_busy[free_t] = 1'b1;
        m_rr = (gp + 1) % P;
      end
      if (rv && m_busy[rt] && !(exp_rdy != '0 && rt == free_t)) m_busy[rt] = 1'b0;
      m_count = held_count();
    end
    cyc++;
    @(negedge user_clk);
  endtask

  initial begin
    int lim;
    user_reset = 1'b1; req_valid = '0; tag_limit = 6'd32;
    release_valid = 1'b0; release_tag = '0;
    @(posedge user_clk);
    @(negedge user_clk);
    model_reset();

    repeat (2) step(1, 2'b11, 32, 0, 0);
    check("req_tag_after_reset", req_tag, 0);

    repeat (3) step(0, 2'b01, 32, 0, 0);     // tags 0,1,2 to port0
    step(0, 2'b00, 32, 0, 0);

    step(1, 2'b00, 32, 0, 0);
    repeat (4) step(0, 2'b11, 32, 0, 0);     // alternating ports

    repeat (30) step(0, 2'b11, 32, 0, 0);    // fill to 32
    step(0, 2'b11, 32, 1, 7);
    repeat (2) step(0, 2'b11, 32, 0, 0);     // tag 7 regranted, full again

    step(1, 2'b00, 32, 0, 0);
    repeat (6) step(0, 2'b11, 4, 0, 0);
    repeat (3) step(0, 2'b11, 6, 0, 0);
    step(0, 2'b11, 0, 0, 0);

    step(1, 2'b00, 32, 0, 0);
    step(0, 2'b00, 32, 1, 5);                // release of a free tag
    repeat (2) step(0, 2'b00, 32, 0, 0);

    repeat (4) step(0, 2'b01, 32, 0, 0);
    step(0, 2'b01, 32, 1, 0);                // release 0 with a grant of 4
    step(0, 2'b01, 32, 0, 0);                // tag 0 again

    repeat (5) step(0, 2'b11, 32, 0, 0);
    repeat (2) step(1, 2'b11, 32, 0, 0);
    step(0, 2'b00, 32, 1, 3);                // pre-reset tag -> error
    repeat (2) step(0, 2'b01, 32, 0, 0);

    lim = 32;
    for (int n = 0; n < 600; n++) begin
      bit rst, rv;
      int rt;
      if ($urandom_range(0, 29) == 0) lim = $urandom_range(0, 40);
      rst = ($urandom_range(0, 199) == 0);
      rv  = ($urandom_range(0, 9) < 4);
      rt  = ($urandom_range(0, 9) < 8 && m_count > 0) ? pick_busy() : $urandom_range(0, TC - 1);
      step(rst, P'($urandom_range(0, (1 << P) - 1)), lim, rv, rt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
